// File: rtl/button_event_ctrl.sv
// Button event scheduler: press edges (and, with BTN_AUTOREPEAT_EN, long-press repeats) become pending bits,
// which are arbitrated round-robin onto one valid/ready port. A grant lands one cycle after a request; the slot holds while !evt_ready.
module button_event_ctrl #(
    parameter int N_BTN    = 4,
    parameter int ID_W     = 2,
    parameter int CNT_W    = 24,
    parameter int HOLD_CYC = 5000000,
    parameter int REP_CYC  = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_deb,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_rep,
    output logic [N_BTN-1:0] pend,
    output logic [7:0]       drop_cnt
);

    logic [N_BTN-1:0] btn_prev, rep, press, req, req_rep;
    logic [N_BTN-1:0] pend_nxt, rep_nxt, gnt_oh;
    logic [ID_W-1:0]  rr_ptr, gnt_id, ptr_nxt;
    logic             slot_free, gnt_vld, gnt_rep;
    logic [7:0]       drop_nxt;

    assign press     = btn_deb & ~btn_prev;
    assign slot_free = ~evt_valid | evt_ready;

`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} hold_t;

    hold_t            state     [N_BTN];
    hold_t            state_nxt [N_BTN];
    logic [CNT_W-1:0] cnt       [N_BTN];
    logic [CNT_W-1:0] cnt_nxt   [N_BTN];
    logic [N_BTN-1:0] rep_req;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BTN; i++) begin
            if (rst) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end else begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    // Release wins over a terminal count reached in the same cycle.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            rep_req[i]   = 1'b0;
            if (!btn_deb[i]) begin
                state_nxt[i] = IDLE;
                cnt_nxt[i]   = '0;
            end else begin
                case (state[i])
                    IDLE: begin
                        if (press[i]) begin
                            state_nxt[i] = HOLD;
                            cnt_nxt[i]   = '0;
                        end
                    end
                    HOLD: begin
                        if (cnt[i] == CNT_W'(HOLD_CYC - 1)) begin
                            state_nxt[i] = REPEAT;
                            cnt_nxt[i]   = '0;
                            rep_req[i]   = 1'b1;
                        end else begin
                            cnt_nxt[i] = cnt[i] + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (cnt[i] == CNT_W'(REP_CYC - 1)) begin
                            cnt_nxt[i] = '0;
                            rep_req[i] = 1'b1;
                        end else begin
                            cnt_nxt[i] = cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt[i] = IDLE;
                        cnt_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    assign req     = press | rep_req;
    assign req_rep = rep_req & ~press;
`else
    logic unused_cfg;
    assign unused_cfg = ^{CNT_W, HOLD_CYC, REP_CYC};
    assign req        = press;
    assign req_rep    = '0;
`endif

    // Round-robin scan starting at rr_ptr, wrapping at N_BTN-1.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        gnt_rep = 1'b0;
        gnt_oh  = '0;
        ptr_nxt = rr_ptr;
        for (int off = 0; off < N_BTN; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N_BTN) idx = idx - N_BTN;
            if (!gnt_vld && pend[idx]) begin
                gnt_vld     = 1'b1;
                gnt_id      = ID_W'(idx);
                gnt_rep     = rep[idx];
                gnt_oh[idx] = slot_free;
                ptr_nxt     = (idx == N_BTN - 1) ? '0 : ID_W'(idx + 1);
            end
        end
    end

    // A request meeting a granted pend bit re-arms it; meeting an ungranted one is a drop.
    always_comb begin
        int drop_sum;
        drop_sum = int'(drop_cnt);
        pend_nxt = pend;
        rep_nxt  = rep;
        for (int i = 0; i < N_BTN; i++) begin
            if (req[i]) begin
                if (pend[i] && !gnt_oh[i]) begin
                    drop_sum = drop_sum + 1;
                end else begin
                    pend_nxt[i] = 1'b1;
                    rep_nxt[i]  = req_rep[i];
                end
            end else if (gnt_oh[i]) begin
                pend_nxt[i] = 1'b0;
            end
        end
        drop_nxt = (drop_sum > 255) ? 8'hff : 8'(drop_sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev  <= '0;
            pend      <= '0;
            rep       <= '0;
            drop_cnt  <= '0;
            rr_ptr    <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_rep   <= 1'b0;
        end else begin
            btn_prev <= btn_deb;
            pend     <= pend_nxt;
            rep      <= rep_nxt;
            drop_cnt <= drop_nxt;
            if (slot_free) begin
                evt_valid <= gnt_vld;
                if (gnt_vld) begin
                    evt_id  <= gnt_id;
                    evt_rep <= gnt_rep;
                    rr_ptr  <= ptr_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Randomized and directed bench for button_event_ctrl against a schedule-based reference model.
`timescale 1ns/1ps
module tb_button_event_ctrl;
    localparam int N    = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_deb = '0;
    logic         evt_ready = 1'b0;
    logic         evt_valid, evt_rep;
    logic [1:0]   evt_id;
    logic [N-1:0] pend;
    logic [7:0]   drop_cnt;
    logic [15:0]  dut_vec;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Reference model: pending set, held slot, and per-button hold age since press.
    logic [N-1:0] m_prev, m_pend, m_rep;
    bit           m_valid, m_erep;
    int           m_id, m_rr, m_drop;
    int           age [N];

    always #5 clk = ~clk;

    button_event_ctrl #(.N_BTN(N), .ID_W(2), .CNT_W(24), .HOLD_CYC(HOLD), .REP_CYC(REP)) dut (
        .clk(clk), .rst(rst), .btn_deb(btn_deb), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_id(evt_id), .evt_rep(evt_rep), .pend(pend), .drop_cnt(drop_cnt)
    );

    assign dut_vec = {evt_valid, evt_id, evt_rep, pend, drop_cnt};

    function automatic logic [15:0] model_vec();
        return {m_valid, 2'(m_id), m_erep, m_pend, 8'(m_drop)};
    endfunction

    task automatic model_edge(input logic r, input logic [N-1:0] b, input logic rdy);
        logic [N-1:0] np, nr;
        bit free, rq, rr;
        int g;
        if (r) begin
            m_prev = '0; m_pend = '0; m_rep = '0; m_valid = 0; m_erep = 0;
            m_id = 0; m_rr = 0; m_drop = 0;
            for (int i = 0; i < N; i++) age[i] = -1;
            return;
        end
        free = !m_valid || rdy;
        g = -1;
        if (free)
            for (int k = 0; k < N; k++)
                if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
        np = m_pend;
        nr = m_rep;
        if (g >= 0) np[g] = 1'b0;
        for (int i = 0; i < N; i++) begin
            rq = b[i] && !m_prev[i];
            rr = 0;
`ifdef BTN_AUTOREPEAT_EN
            if (!b[i]) age[i] = -1;
            else if (rq) age[i] = 0;
            else if (age[i] >= 0) begin
                age[i]++;
                if (age[i] >= HOLD && (age[i] - HOLD) % REP == 0) begin
                    rq = 1; rr = 1;
                end
            end
`endif
            if (rq) begin
                if (np[i]) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    np[i] = 1'b1;
                    nr[i] = rr;
                end
            end
        end
        if (free) begin
            if (g >= 0) begin
                m_valid = 1; m_id = g; m_erep = m_rep[g]; m_rr = (g + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        m_pend = np;
        m_rep  = nr;
        m_prev = b;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic r, input logic [N-1:0] b, input logic rdy);
        rst = r; btn_deb = b; evt_ready = rdy;
        @(posedge clk);
        model_edge(r, b, rdy);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(1, 4'b1111, 0);
            vecs++;
            if (dut_vec !== 16'h0) begin
                errs++; $display("FAIL reset_state cyc=%0d got=%h want=0000", cyc, dut_vec);
            end
        end
        step(0, 4'b1111, 0);
        vecs++;
        if (pend !== 4'b1111) begin
            errs++; $display("FAIL reset_first_edge got pend=%b want=1111", pend);
        end
        for (int k = 0; k < 8; k++) begin
            step(0, 4'b1111, 1);
            vecs++;
            if (dut_vec !== model_vec()) begin
                errs++; $display("FAIL reset_drain cyc=%0d got=%h want=%h", cyc, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_single();
        step(1, 4'b0000, 1);
        step(0, 4'b0000, 1);
        step(0, 4'b0100, 1);
        vecs++;
        if ({evt_valid, pend} !== {1'b0, 4'b0100}) begin
            errs++; $display("FAIL single_pend got v=%b pend=%b want v=0 pend=0100", evt_valid, pend);
        end
        step(0, 4'b0100, 1);
        vecs++;
        if ({evt_valid, evt_id, evt_rep, pend} !== {1'b1, 2'd2, 1'b0, 4'b0000}) begin
            errs++; $display("FAIL single_event got v=%b id=%0d rep=%b pend=%b want v=1 id=2 rep=0 pend=0000",
                             evt_valid, evt_id, evt_rep, pend);
        end
        step(0, 4'b0100, 1);
        vecs++;
        if (evt_valid !== 1'b0) begin
            errs++; $display("FAIL single_one_cycle got v=%b want v=0", evt_valid);
        end
        step(0, 4'b0000, 1);
    endtask

    task automatic test_order();
        logic [11:0] ids;
        int n, first, last;
        ids = '0; n = 0; first = 0; last = 0;
        step(1, 4'b0000, 0);
        step(0, 4'b1011, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 4'b1011, 0);
            vecs++;
            if (dut_vec !== model_vec()) begin
                errs++; $display("FAIL order_stall cyc=%0d got=%h want=%h", cyc, dut_vec, model_vec());
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (evt_valid) begin
                ids = {ids[7:0], 2'b00, evt_id};
                if (n == 0) first = k;
                last = k;
                n++;
            end
            step(0, 4'b1011, 1);
            vecs++;
            if (dut_vec !== model_vec()) begin
                errs++; $display("FAIL order_drain cyc=%0d got=%h want=%h", cyc, dut_vec, model_vec());
            end
        end
        vecs++;
        if (n !== 3 || ids !== 12'h013 || last - first !== 2) begin
            errs++; $display("FAIL order_ids got n=%0d ids=%h span=%0d want n=3 ids=013 span=2", n, ids, last - first);
        end
        step(0, 4'b0000, 1);
    endtask

    task automatic test_overflow();
        int acc;
        logic [N-1:0] pat [5];
        acc = 0;
        pat = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
        step(1, 4'b0000, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, pat[k], 0);
            vecs++;
            if (dut_vec !== model_vec()) begin
                errs++; $display("FAIL ovf_seq cyc=%0d got=%h want=%h", cyc, dut_vec, model_vec());
            end
        end
        vecs++;
        if (drop_cnt !== 8'd1) begin
            errs++; $display("FAIL ovf_drop got=%0d want=1", drop_cnt);
        end
        for (int k = 0; k < 5; k++) begin
            if (evt_valid) acc++;
            step(0, 4'b0000, 1);
        end
        vecs++;
        if (acc !== 2) begin
            errs++; $display("FAIL ovf_delivered got=%0d want=2", acc);
        end
    endtask

    task automatic test_autorepeat();
        int offs[$];
        int reps[$];
        int exp_off[$];
        int exp_rep[$];
`ifdef BTN_AUTOREPEAT_EN
        exp_off = {0, HOLD, HOLD + REP, HOLD + 2 * REP, HOLD + 3 * REP};
        exp_rep = {0, 1, 1, 1, 1};
`else
        exp_off = {0};
        exp_rep = {0};
`endif
        step(1, 4'b0000, 1);
        step(0, 4'b0000, 1);
        for (int k = 0; k < 70; k++) begin
            step(0, (k < 50) ? 4'b0001 : 4'b0000, 1);
            vecs++;
            if (dut_vec !== model_vec()) begin
                errs++; $display("FAIL rep_seq cyc=%0d got=%h want=%h", cyc, dut_vec, model_vec());
            end
            if (evt_valid) begin
                offs.push_back(cyc);
                reps.push_back(int'(evt_rep));
            end
        end
        vecs++;
        if (offs.size() !== exp_off.size()) begin
            errs++; $display("FAIL rep_count got=%0d want=%0d", offs.size(), exp_off.size());
        end else begin
            for (int i = 1; i < offs.size(); i++) begin
                vecs++;
                if (offs[i] - offs[0] !== exp_off[i] || reps[i] !== exp_rep[i]) begin
                    errs++; $display("FAIL rep_event%0d got off=%0d rep=%0d want off=%0d rep=%0d",
                                     i, offs[i] - offs[0], reps[i], exp_off[i], exp_rep[i]);
                end
            end
            vecs++;
            if (reps[0] !== 0) begin
                errs++; $display("FAIL rep_press got rep=%0d want 0", reps[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        step(1, 4'b0000, 1);
        step(0, 4'b1111, 1);
        for (int k = 0; k < 6; k++) begin
            step(0, 4'b1111, 1);
            if (evt_valid) n++;
            vecs++;
            if (dut_vec !== model_vec()) begin
                errs++; $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, dut_vec, model_vec());
            end
        end
        vecs++;
        if (n !== 4) begin
            errs++; $display("FAIL b2b_count got=%0d want=4", n);
        end
        step(0, 4'b0000, 1);
    endtask

    task automatic test_reset_mid();
        step(1, 4'b0000, 0);
        step(0, 4'b1011, 0);
        step(0, 4'b1011, 0);
        vecs++;
        if ({evt_valid, pend} !== {1'b1, 4'b1010}) begin
            errs++; $display("FAIL mid_pre got v=%b pend=%b want v=1 pend=1010", evt_valid, pend);
        end
        step(1, 4'b0000, 0);
        vecs++;
        if (dut_vec !== 16'h0) begin
            errs++; $display("FAIL mid_reset got=%h want=0000", dut_vec);
        end
        for (int k = 0; k < 5; k++) begin
            step(0, 4'b0000, 1);
            vecs++;
            if (evt_valid !== 1'b0 || pend !== 4'b0000) begin
                errs++; $display("FAIL mid_replay cyc=%0d got v=%b pend=%b want v=0 pend=0000", cyc, evt_valid, pend);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] b;
        logic r, rdy;
        b = '0;
        step(1, b, 0);
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(31) == 0) b[i] = ~b[i];
            rdy = ($urandom_range(3) != 0);
            r   = ($urandom_range(499) == 0);
            step(r, b, rdy);
            vecs++;
            if (dut_vec !== model_vec()) begin
                errs++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) age[i] = -1;
        m_prev = '0; m_pend = '0; m_rep = '0; m_valid = 0; m_erep = 0;
        m_id = 0; m_rr = 0; m_drop = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_order();
        test_overflow();
        test_autorepeat();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
